sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Parametrised single-clock FIFO: configurable data width, depth and watermarks.
//   Provides registered status flags, occupancy count and overflow/underflow pulses.
//   Buffers streams between producer/consumer blocks in the same clock domain.
//   Successor to the fixed 64-deep FIFO counter; adds watermarks, error flags and an optional FWFT mode.
// PARAMETERS
//   WIDTH          8   data width in bits (>=1)
//   DEPTH         16   number of entries; power of two, >=4
//   AFULL_THRESH  12   almost_full asserted when count >= AFULL_THRESH (1..DEPTH-1)
//   AEMPTY_THRESH  4   almost_empty asserted when count <= AEMPTY_THRESH (0..DEPTH-2)
// PORTS
//   clk           in   1              clock, rising edge
//   rst           in   1              reset; asynchronous, active-high
//   wr_en         in   1              write request
//   wr_data       in   WIDTH          write data
//   rd_en         in   1              read request (pop in FWFT mode)
//   rd_data       out  WIDTH          read data
//   rd_valid      out  1              rd_data holds a valid popped word
//   full          out  1              count == DEPTH
//   empty         out  1              count == 0
//   almost_full   out  1              count >= AFULL_THRESH
//   almost_empty  out  1              count <= AEMPTY_THRESH
//   count         out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//   overflow      out  1              1-cycle pulse: write rejected
//   underflow     out  1              1-cycle pulse: read rejected
// BEHAVIOUR
//   Reset:
//     - Pointers and count = 0; empty=1, almost_empty=1; full=0, almost_full=0.
//     - rd_data=0, rd_valid=0, overflow=0, underflow=0.
//     - Memory contents are not reset.
//     - Reset mid-operation discards all stored data immediately (async).
//   Accept rules:
//     - wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty; both evaluated on registered flags.
//     - Full + wr_en + rd_en: read accepted, write rejected, overflow pulses; count becomes DEPTH-1.
//     - Empty + wr_en + rd_en: write accepted, read rejected, underflow pulses; count becomes 1.
//     - Both accepted: count unchanged; both pointers advance.
//   Pointers: log2(DEPTH) bits, increment on accept, wrap DEPTH-1 -> 0 naturally.
//   Count: +1 on wr_acc only; -1 on rd_acc only; never exceeds DEPTH or goes below 0.
//   Flags: all registered, computed from the next count, so valid the cycle after the edge that changes count.
//   Standard mode (macro undefined):
//     - rd_data = mem[rd_ptr] registered on rd_acc; latency 1 cycle.
//     - rd_valid pulses 1 cycle after each rd_acc.
//     - rd_data holds its value when there is no rd_acc.
//   Written word is readable the cycle after wr_acc (empty deasserts then).
//   overflow/underflow are registered 1-cycle pulses, one cycle after the rejected request.
// CONFIGURATION
//   SYNC_FIFO_FWFT_EN defined: first-word-fall-through.
//     - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
//     - rd_en acknowledges/pops the head word; the next word appears the same cycle the pointer advances.
//     - Write into empty FIFO: word visible on rd_data the cycle after wr_acc.
//   Undefined: standard registered-read mode as above.
// STRUCTURE
//   Package sync_fifo_pkg:
//     - Pointer/count width helpers: PTR_W = $clog2(DEPTH), CNT_W = PTR_W+1.
//     - Parameter-legality checks.
//   Sub-module sync_fifo_mem: simple dual-port RAM, one write port, one async read address.
//   Parent holds pointers, counter, flags and the read register.
// TESTING   (WIDTH=8, DEPTH=16, AFULL=12, AEMPTY=4)
//   Reset, idle -> empty=1, almost_empty=1, count=0, rd_data=0, no pulses.
//   Write 0x00..0x0F (16 writes) -> count=16, full=1, almost_full from count 12; 17th write -> overflow pulse, count stays 16.
//   Read 16 words -> rd_data 0x00..0x0F in order, rd_valid 1 cycle after each rd_en; 17th read -> underflow pulse.
//   Simultaneous wr+rd at count=8 for 40 cycles -> count stays 8, data order preserved across pointer wrap.
//   Full + wr_en + rd_en -> count 15, overflow=1; empty + wr_en + rd_en -> count 1, underflow=1.
//   Assert rst at count=10 mid-burst -> all flags/count reset at once; next write 0xAA read back first.
//   FWFT build: write 0x5A into empty -> rd_data=0x5A, rd_valid=1 next cycle with no rd_en.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared width helpers and parameter-legality check for the parametrised sync FIFO.
package sync_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_legal(input int width, input int depth,
                                        input int afull, input int aempty);
        return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (afull >= 1) && (afull <= depth - 1) &&
               (aempty >= 0) && (aempty <= depth - 2);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read address.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered flags, watermarks and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

    generate
        if (!params_legal(WIDTH, DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
            $error("sync_fifo_param: illegal WIDTH/DEPTH/threshold combination");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] mem_rd;

    // Acceptance uses the registered flags, so a full FIFO still pops on a joint request.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_nxt = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AFULL_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown directly; masked to zero while empty so stale RAM never leaks out.
    assign rd_data  = empty ? '0 : mem_rd;
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= mem_rd;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] q[$];
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_ovf;
    bit         exp_unf;

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the queue model predicts what the edge should produce.
    task automatic step(input bit w, input bit r, input logic [7:0] d);
        bit fm;
        bit em;
        fm = (q.size() == 16);
        em = (q.size() == 0);
        wr_en = w; rd_en = r; wr_data = d;
        exp_ovf = w && fm;
        exp_unf = r && em;
        exp_valid = 0;
        if (r && !em) begin
            exp_data  = q.pop_front();
            exp_valid = 1;
        end
        if (w && !fm) q.push_back(d);
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0;
    endtask

    task automatic test_reset();
        rst = 1; wr_en = 0; rd_en = 0; wr_data = 0;
        q.delete(); exp_data = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        step(0, 0, 8'h00);
        vectors++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got empty=%b aempty=%b want 1 1", empty, almost_empty); end
        vectors++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_full: got full=%b afull=%b want 0 0", full, almost_full); end
        vectors++; if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd: got data=%0h valid=%b want 0 0", rd_data, rd_valid); end
        vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_pulses: got ovf=%b unf=%b want 0 0", overflow, underflow); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'(i));
            vectors++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
            vectors++; if (almost_full !== (i + 1 >= 12)) begin errors++; $display("FAIL fill_afull: count %0d got %b want %b", i + 1, almost_full, (i + 1 >= 12)); end
            vectors++; if (full !== (i + 1 == 16)) begin errors++; $display("FAIL fill_full: count %0d got %b want %b", i + 1, full, (i + 1 == 16)); end
            vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf: got %b want 0", overflow); end
        end
        step(1, 0, 8'hFF);
        vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse: got %b want 1", overflow); end
        vectors++; if (count !== 5'd16) begin errors++; $display("FAIL overflow_count: got %0d want 16", count); end
        step(0, 0, 8'h00);
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b want 0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'h00);
            vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin errors++; $display("FAIL drain_data: got valid=%b data=%0h want 1 %0h", rd_valid, rd_data, i); end
            vectors++; if (count !== 5'(15 - i)) begin errors++; $display("FAIL drain_count: got %0d want %0d", count, 15 - i); end
            vectors++; if (almost_empty !== (15 - i <= 4) || empty !== (i == 15)) begin errors++; $display("FAIL drain_flags: got aempty=%b empty=%b at count %0d", almost_empty, empty, 15 - i); end
        end
        step(0, 0, 8'h00);
        vectors++; if (rd_valid !== 1'b0 || rd_data !== 8'h0F) begin errors++; $display("FAIL drain_hold: got valid=%b data=%0h want 0 0f", rd_valid, rd_data); end
        step(0, 1, 8'h00);
        vectors++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL underflow_pulse: got unf=%b valid=%b want 1 0", underflow, rd_valid); end
        step(0, 0, 8'h00);
        vectors++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b want 0", underflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 8'($urandom));
            vectors++; if (count !== 5'd8) begin errors++; $display("FAIL b2b_count: got %0d want 8", count); end
            vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_data) begin errors++; $display("FAIL b2b_data: got valid=%b data=%0h want 1 %0h", rd_valid, rd_data, exp_data); end
        end
        while (q.size() > 0) begin
            step(0, 1, 8'h00);
            vectors++; if (rd_data !== exp_data) begin errors++; $display("FAIL b2b_drain: got %0h want %0h", rd_data, exp_data); end
        end
    endtask

    task automatic test_full_empty_both();
        logic [7:0] d;
        while (q.size() < 16) step(1, 0, 8'($urandom));
        step(1, 1, 8'hC3);
        vectors++; if (count !== 5'd15 || overflow !== 1'b1) begin errors++; $display("FAIL full_both: got count=%0d ovf=%b want 15 1", count, overflow); end
        vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_data) begin errors++; $display("FAIL full_both_rd: got valid=%b data=%0h want 1 %0h", rd_valid, rd_data, exp_data); end
        while (q.size() > 0) step(0, 1, 8'h00);
        d = 8'($urandom);
        step(1, 1, d);
        vectors++; if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL empty_both: got count=%0d unf=%b valid=%b want 1 1 0", count, underflow, rd_valid); end
        step(0, 1, 8'h00);
        vectors++; if (rd_data !== d || empty !== 1'b1) begin errors++; $display("FAIL empty_both_rd: got data=%0h empty=%b want %0h 1", rd_data, empty, d); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom));
        wr_en = 1; wr_data = 8'h77;
        #2 rst = 1;
        #1;
        vectors++; if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("FAIL async_rst_count: got count=%0d empty=%b aempty=%b want 0 1 1", count, empty, almost_empty); end
        vectors++; if (full !== 1'b0 || almost_full !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL async_rst_out: full=%b afull=%b valid=%b data=%0h want 0 0 0 0", full, almost_full, rd_valid, rd_data); end
        wr_en = 0;
        q.delete(); exp_data = 0;
        @(posedge clk); #1;
        rst = 0;
        step(1, 0, 8'hAA);
        step(0, 1, 8'h00);
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'hAA || empty !== 1'b1) begin errors++; $display("FAIL post_rst_read: got valid=%b data=%0h empty=%b want 1 aa 1", rd_valid, rd_data, empty); end
    endtask

    task automatic test_random();
        int wp;
        int rp;
        for (int i = 0; i < 400; i++) begin
            wp = ((i / 50) % 2 == 0) ? 75 : 25;
            rp = 100 - wp;
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
            vectors++; if (count !== 5'(q.size())) begin errors++; $display("FAIL rand_count: got %0d want %0d", count, q.size()); end
            vectors++; if (full !== (q.size() == 16) || empty !== (q.size() == 0)) begin errors++; $display("FAIL rand_flags: got full=%b empty=%b at %0d", full, empty, q.size()); end
            vectors++; if (almost_full !== (q.size() >= 12) || almost_empty !== (q.size() <= 4)) begin errors++; $display("FAIL rand_wm: got afull=%b aempty=%b at %0d", almost_full, almost_empty, q.size()); end
            vectors++; if (rd_valid !== exp_valid || rd_data !== exp_data) begin errors++; $display("FAIL rand_rd: got valid=%b data=%0h want %b %0h", rd_valid, rd_data, exp_valid, exp_data); end
            vectors++; if (overflow !== exp_ovf || underflow !== exp_unf) begin errors++; $display("FAIL rand_pulse: got ovf=%b unf=%b want %b %b", overflow, underflow, exp_ovf, exp_unf); end
        end
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        step(1, 0, 8'h5A);
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin errors++; $display("FAIL fwft_first: got valid=%b data=%0h want 1 5a", rd_valid, rd_data); end
        step(1, 0, 8'h3C);
        vectors++; if (rd_data !== 8'h5A || count !== 5'd2) begin errors++; $display("FAIL fwft_head: got data=%0h count=%0d want 5a 2", rd_data, count); end
        step(0, 1, 8'h00);
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin errors++; $display("FAIL fwft_pop: got valid=%b data=%0h want 1 3c", rd_valid, rd_data); end
        step(0, 1, 8'h00);
        vectors++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL fwft_empty: got valid=%b empty=%b want 0 1", rd_valid, empty); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
        test_fill();
`else
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_empty_both();
        test_mid_reset();
        test_random();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
